// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row synchronizer, per-pass key
// classification, debounce FSM and single-cycle command pulses for the BCD entry register.
module keypad_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] digit,
    output logic       load,
    output logic       bksp,
    output logic       clear,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic [1:0] state
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DIV_LAST    = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_DONE    = CW'(DEBOUNCE_SCANS);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam bit            SINGLE_SCAN = (DEBOUNCE_SCANS == 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_RELEASE  = 2'd2
    } state_t;

    logic [3:0]    row_meta;
    logic [3:0]    row_sync;
    logic [DW-1:0] div;
    logic [1:0]    col_idx;
    logic [1:0]    acc_cnt;
    logic [3:0]    acc_key;

    state_t        st;
    logic [CW-1:0] cnt;
    logic [3:0]    cand;

    logic          sample;
    logic          pass_end;
    logic [3:0]    row_low;
    logic [2:0]    col_hits;
    logic [1:0]    hit_row;
    logic [3:0]    col_key;
    logic [2:0]    total;
    logic [1:0]    pass_cnt;
    logic [3:0]    pass_key;
    logic          pass_empty;
    logic          pass_single;
    logic          accept;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'h0: k = 4'd1;
            4'h1: k = 4'd2;
            4'h2: k = 4'd3;
            4'h3: k = 4'd10;
            4'h4: k = 4'd4;
            4'h5: k = 4'd5;
            4'h6: k = 4'd6;
            4'h7: k = 4'd11;
            4'h8: k = 4'd7;
            4'h9: k = 4'd8;
            4'hA: k = 4'd9;
            4'hB: k = 4'd12;
            4'hC: k = 4'd14;
            4'hD: k = 4'd0;
            4'hE: k = 4'd15;
            default: k = 4'd13;
        endcase
        return k;
    endfunction

    assign col      = ~(4'b0001 << col_idx);
    assign state    = st;
    assign sample   = (div == DIV_LAST);
    assign pass_end = sample && (col_idx == 2'd3);
    assign row_low  = ~row_sync;

    // Classify the current column sample, then fold it into the running pass result.
    always_comb begin
        col_hits = 3'd0;
        hit_row  = 2'd0;
        for (int r = 0; r < 4; r++) begin
            if (row_low[r]) begin
                col_hits = col_hits + 3'd1;
                hit_row  = 2'(r);
            end
        end
        col_key     = key_map(hit_row, col_idx);
        total       = {1'b0, acc_cnt} + col_hits;
        pass_cnt    = (total >= 3'd2) ? 2'd2 : total[1:0];
        pass_key    = (acc_cnt == 2'd0) ? col_key : acc_key;
        pass_empty  = (pass_cnt == 2'd0);
        pass_single = (pass_cnt == 2'd1);
    end

    always_comb begin
        accept = 1'b0;
        if (pass_end && pass_single) begin
            if (st == ST_IDLE && SINGLE_SCAN)
                accept = 1'b1;
            else if (st == ST_DEBOUNCE && pass_key == cand && (cnt + CNT_ONE) == CNT_DONE)
                accept = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
            div      <= '0;
            col_idx  <= 2'd0;
            acc_cnt  <= 2'd0;
            acc_key  <= 4'd0;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
            if (sample) begin
                div     <= '0;
                col_idx <= col_idx + 2'd1;
                if (col_idx == 2'd3) begin
                    acc_cnt <= 2'd0;
                    acc_key <= 4'd0;
                end else begin
                    acc_cnt <= pass_cnt;
                    acc_key <= pass_key;
                end
            end else begin
                div <= div + 1'b1;
            end
        end
    end

    // Debounce FSM: acts only at pass boundaries; pulses default low every cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st        <= ST_IDLE;
            cnt       <= '0;
            cand      <= 4'd0;
            digit     <= 4'd0;
            key_code  <= 4'd0;
            load      <= 1'b0;
            bksp      <= 1'b0;
            clear     <= 1'b0;
            key_valid <= 1'b0;
        end else begin
            load      <= 1'b0;
            bksp      <= 1'b0;
            clear     <= 1'b0;
            key_valid <= 1'b0;

            if (accept) begin
                key_valid <= 1'b1;
                key_code  <= pass_key;
                if (pass_key <= 4'd9) begin
                    load  <= 1'b1;
                    digit <= pass_key;
                end
                bksp  <= (pass_key == 4'd10);
                clear <= (pass_key == 4'd12);
                st    <= ST_RELEASE;
                cnt   <= '0;
            end else if (pass_end) begin
                case (st)
                    ST_IDLE: begin
                        if (pass_single) begin
                            st   <= ST_DEBOUNCE;
                            cand <= pass_key;
                            cnt  <= CNT_ONE;
                        end else if (!pass_empty) begin
                            st  <= ST_RELEASE;
                            cnt <= '0;
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (pass_single) begin
                            if (pass_key == cand) begin
                                cnt <= cnt + CNT_ONE;
                            end else begin
                                cand <= pass_key;
                                cnt  <= CNT_ONE;
                            end
                        end else if (pass_empty) begin
                            st  <= ST_IDLE;
                            cnt <= '0;
                        end else begin
                            st  <= ST_RELEASE;
                            cnt <= '0;
                        end
                    end
                    ST_RELEASE: begin
                        if (pass_empty) begin
                            if ((cnt + CNT_ONE) == CNT_DONE) begin
                                st  <= ST_IDLE;
                                cnt <= '0;
                            end else begin
                                cnt <= cnt + CNT_ONE;
                            end
                        end else begin
                            cnt <= '0;
                        end
                    end
                    default: begin
                        st  <= ST_IDLE;
                        cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model drives rows from the column strobe,
// stimulus pushes expected events, a monitor pops and compares each pulse.
module tb_keypad_scanner;

    localparam int SCAN_DIV       = 4;
    localparam int DEBOUNCE_SCANS = 3;
    localparam int PASS           = 4 * SCAN_DIV;
    localparam int EW             = 27;

    // Key bit index = row*4 + col
    localparam logic [15:0] K1   = 16'h0001;
    localparam logic [15:0] K2   = 16'h0002;
    localparam logic [15:0] KA   = 16'h0008;
    localparam logic [15:0] K4   = 16'h0010;
    localparam logic [15:0] K5   = 16'h0020;
    localparam logic [15:0] K7   = 16'h0100;
    localparam logic [15:0] K8   = 16'h0200;
    localparam logic [15:0] K9   = 16'h0400;
    localparam logic [15:0] KC   = 16'h0800;
    localparam logic [15:0] KH   = 16'h4000;
    localparam logic [15:0] NONE = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  digit;
    logic        load;
    logic        bksp;
    logic        clear;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [1:0]  state;
    logic [15:0] keys = 16'h0000;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [EW-1:0] exp_q[$];

    keypad_scanner #(
        .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .row(row),
        .col(col),
        .digit(digit),
        .load(load),
        .bksp(bksp),
        .clear(clear),
        .key_code(key_code),
        .key_valid(key_valid),
        .state(state)
    );

    // Clock/reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Keypad matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_ev(input int at, input logic [3:0] code, input logic [3:0] dig,
                             input logic ld, input logic bk, input logic cl);
        exp_q.push_back({16'(at), code, dig, ld, bk, cl});
    endtask

    // Driver: hold a key set for whole scan passes, starting right after a pass boundary.
    task automatic hold(input logic [15:0] k, input int passes);
        keys = k;
        repeat (passes * PASS) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if ((load | bksp | clear | key_valid) === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {28'd0, load, bksp, clear, key_valid}, 32'd0);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                check("ev_cycle", cyc, {16'd0, e[26:11]});
                check("ev_key_valid", {31'd0, key_valid}, 32'd1);
                check("ev_key_code", {28'd0, key_code}, {28'd0, e[10:7]});
                check("ev_digit", {28'd0, digit}, {28'd0, e[6:3]});
                check("ev_load", {31'd0, load}, {31'd0, e[2]});
                check("ev_bksp", {31'd0, bksp}, {31'd0, e[1]});
                check("ev_clear", {31'd0, clear}, {31'd0, e[0]});
            end
        end
    end

    initial begin
        int c0;
        logic [3:0] exp_col;

        // Test 1: reset values and column walk
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_col", {28'd0, col}, 32'h0000000E);
        check("rst_pulses", {28'd0, load, bksp, clear, key_valid}, 32'd0);
        check("rst_digit", {28'd0, digit}, 32'd0);
        check("rst_key_code", {28'd0, key_code}, 32'd0);
        check("rst_state", {30'd0, state}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 2 * PASS; i++) begin
            @(negedge clk);
            exp_col = 4'b1110;
            case ((i / SCAN_DIV) % 4)
                1: exp_col = 4'b1101;
                2: exp_col = 4'b1011;
                3: exp_col = 4'b0111;
                default: exp_col = 4'b1110;
            endcase
            check("col_scan", {28'd0, col}, {28'd0, exp_col});
        end
        @(posedge clk);
        #1;

        // Test 2: '5' held for 12 passes gives exactly one event at the end of pass 3
        c0 = cyc;
        expect_ev(c0 + 3 * PASS, 4'd5, 4'd5, 1'b1, 1'b0, 1'b0);
        hold(K5, 12);
        hold(NONE, 3);

        // Test 3: bounce on '7'; the third consecutive pressed pass accepts
        hold(K7, 2);
        hold(NONE, 1);
        hold(K7, 2);
        c0 = cyc;
        expect_ev(c0 + PASS, 4'd7, 4'd7, 1'b1, 1'b0, 1'b0);
        hold(K7, 3);
        hold(NONE, 3);

        // Test 4: A, C and # ; digit keeps 7
        c0 = cyc;
        expect_ev(c0 + 3 * PASS, 4'd10, 4'd7, 1'b0, 1'b1, 1'b0);
        hold(KA, 3);
        hold(NONE, 3);
        c0 = cyc;
        expect_ev(c0 + 3 * PASS, 4'd12, 4'd7, 1'b0, 1'b0, 1'b1);
        hold(KC, 3);
        hold(NONE, 3);
        c0 = cyc;
        expect_ev(c0 + 3 * PASS, 4'd15, 4'd7, 1'b0, 1'b0, 1'b0);
        hold(KH, 3);
        hold(NONE, 3);

        // Test 5: multi-key (different columns, then same column) never accepts
        hold(K1 | K2, 5);
        check("state_multi", {30'd0, state}, 32'd2);
        hold(K2, 4);
        check("state_partial_release", {30'd0, state}, 32'd2);
        hold(NONE, 3);
        check("state_released", {30'd0, state}, 32'd0);
        hold(K1 | K4, 3);
        check("state_multi_same_col", {30'd0, state}, 32'd2);
        hold(NONE, 3);
        c0 = cyc;
        expect_ev(c0 + 3 * PASS, 4'd2, 4'd2, 1'b1, 1'b0, 1'b0);
        hold(K2, 3);
        hold(NONE, 3);

        // Test 6: reset at a pass boundary after 2 passes of '9'
        hold(K9, 2);
        check("state_debounce", {30'd0, state}, 32'd1);
        pulse_reset();
        check("state_after_rst", {30'd0, state}, 32'd0);
        check("col_after_rst", {28'd0, col}, 32'h0000000E);
        c0 = cyc;
        expect_ev(c0 + 3 * PASS, 4'd9, 4'd9, 1'b1, 1'b0, 1'b0);
        hold(K9, 3);
        hold(NONE, 3);

        // Reset mid-pass discards the partial pass and the debounce count
        keys = K8;
        repeat (PASS + 6) @(posedge clk);
        #1;
        pulse_reset();
        c0 = cyc;
        expect_ev(c0 + 3 * PASS, 4'd8, 4'd8, 1'b1, 1'b0, 1'b0);
        hold(K8, 3);
        hold(NONE, 3);

        hold(NONE, 1);
        check("queue_drained", exp_q.size(), 32'd0);
        check("final_digit", {28'd0, digit}, 32'd8);
        check("final_key_code", {28'd0, key_code}, 32'd8);
        check("final_state", {30'd0, state}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
